// File: rtl/gb_pkg.sv
// Shared constants and types for the object (sprite) pipeline.
// The OAM scanner imports this package; it holds no logic of its own.
package gb_pkg;

    localparam int OAM_SPRITES      = 40;
    localparam int OAM_WORDS        = 80;
    localparam int MAX_LINE_SPRITES = 10;
    localparam int SPRITE_Y_OFFSET  = 16;

    typedef struct packed {
        logic [5:0] index;
        logic [7:0] x;
    } obj_hit_t;

endpackage

// File: rtl/oam_scanner.sv
// Mode-2 OAM search: walks the 40 sprite Y/X words in fixed 80-cycle time
// and records up to 10 sprites overlapping the latched scanline.
module oam_scanner
    import gb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ly,
    input  logic        tall,
    output logic [6:0]  oam_addr,
    input  logic [15:0] oam_data,
    output logic        busy,
    output logic        done,
    output logic [3:0]  hit_count,
    input  logic [3:0]  hit_sel,
    output logic [5:0]  hit_index,
    output logic [7:0]  hit_x
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t     state;
    logic [6:0] c;
    logic [7:0] ly_q;
    logic       tall_q;
    logic       hit;
    logic       wr_en;
    obj_hit_t   hit_buf [MAX_LINE_SPRITES];

    // Compare in 9 bits so ly + 16 past 255 and Y = 0 stay exact.
    function automatic logic is_hit(input logic [7:0] line, input logic big,
                                    input logic [7:0] y);
        logic [8:0] l9;
        logic [8:0] y9;
        logic [8:0] diff;
        l9   = {1'b0, line} + 9'(SPRITE_Y_OFFSET);
        y9   = {1'b0, y};
        diff = l9 - y9;
        return (y9 <= l9) && (diff < (big ? 9'd16 : 9'd8));
    endfunction

    assign oam_addr = (state == SCAN) ? {c[6:1], 1'b0} : 7'd0;
    assign hit      = is_hit(ly_q, tall_q, oam_data[7:0]);
    assign wr_en    = (state == SCAN) && !start && c[0] && hit
                      && (hit_count < 4'(MAX_LINE_SPRITES));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit_count <= 4'd0;
            c         <= 7'd0;
            ly_q      <= 8'd0;
            tall_q    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state     <= SCAN;
                busy      <= 1'b1;
                ly_q      <= ly;
                tall_q    <= tall;
                hit_count <= 4'd0;
                c         <= 7'd0;
            end else if (state == SCAN) begin
                if (wr_en)
                    hit_count <= hit_count + 4'd1;
                if (c == 7'(OAM_WORDS - 1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    c     <= 7'd0;
                end else begin
                    c <= c + 7'd1;
                end
            end
        end
    end

    // Entry storage is left unreset; reads beyond hit_count are masked below.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            for (int i = 0; i < MAX_LINE_SPRITES; i++) begin
                if (hit_count == 4'(i))
                    hit_buf[i] <= '{index: c[6:1], x: oam_data[15:8]};
            end
        end
    end

    always_comb begin
        hit_index = 6'd0;
        hit_x     = 8'd0;
        for (int i = 0; i < MAX_LINE_SPRITES; i++) begin
            if ((hit_sel == 4'(i)) && (hit_sel < hit_count)) begin
                hit_index = hit_buf[i].index;
                hit_x     = hit_buf[i].x;
            end
        end
    end

endmodule
